// File: rtl/hdmi_blk_pkg.sv
// Shared constants and state types for the HDMI <-> 8x8 block converters
// (hdmi_to_blocks and blocks_to_hdmi).
package hdmi_blk_pkg;

    localparam int BLOCK_SIZE = 8;

    // Default active raster of the panel
    localparam int H_ACTIVE = 2160;
    localparam int V_ACTIVE = 1200;

    typedef enum logic [1:0] {
        WR_WAIT_VS = 2'd0,
        WR_ACTIVE  = 2'd1,
        WR_DONE    = 2'd2
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_BAND = 1'b1
    } rd_state_t;

    // Counter width that stays legal when the count collapses to 1
    function automatic int width_of(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/band_pingpong_ram.sv
// Two band buffers behind one write port and one registered read port;
// the select bits pick which buffer each port addresses.
module band_pingpong_ram #(
    parameter int DEPTH  = 64,
    parameter int WIDTH  = 48,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic              rd_sel,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem0 [DEPTH];
    logic [WIDTH-1:0] mem1 [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en && !wr_sel) mem0[wr_addr] <= wr_data;
        if (wr_en && wr_sel)  mem1[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= rd_sel ? mem1[rd_addr] : mem0[rd_addr];
    end

endmodule

// File: rtl/hdmi_to_blocks.sv
// Collects 8 HDMI lines into a ping-pong band buffer, then streams the band
// out as 8x8 blocks, row by row within each block.
module hdmi_to_blocks
    import hdmi_blk_pkg::*;
#(
    parameter int N     = 2,
    parameter int X_RES = H_ACTIVE,
    parameter int Y_RES = V_ACTIVE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hdmi_v_sync,
    input  logic                hdmi_h_sync,
    input  logic                hdmi_data_valid,
    input  logic signed [N*8-1:0] hdmi_data_y,
    input  logic signed [N*8-1:0] hdmi_data_cr,
    input  logic signed [N*8-1:0] hdmi_data_cb,
    output logic                blk_valid,
    output logic signed [N*8-1:0] blk_data_y,
    output logic signed [N*8-1:0] blk_data_cr,
    output logic signed [N*8-1:0] blk_data_cb,
    output logic                blk_sob,
    output logic                blk_eob,
    output logic                blk_sof,
    output logic                err_ovf,
    output logic                err_line,
    output wr_state_t           dbg_wr_state,
    output rd_state_t           dbg_rd_state
);

    localparam int COLS   = X_RES / N;
    localparam int DEPTH  = X_RES * BLOCK_SIZE / N;
    localparam int EPB    = BLOCK_SIZE / N;
    localparam int BLKS   = X_RES / BLOCK_SIZE;
    localparam int BANDS  = Y_RES / BLOCK_SIZE;
    localparam int W      = 24 * N;
    localparam int ADDR_W = width_of(DEPTH);
    localparam int COL_W  = width_of(COLS);
    localparam int E_W    = width_of(EPB);
    localparam int B_W    = width_of(BLKS);
    localparam int BAND_W = width_of(BANDS);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [E_W-1:0]    E_LAST    = E_W'(EPB - 1);
    localparam logic [B_W-1:0]    B_LAST    = B_W'(BLKS - 1);
    localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(BANDS - 1);

    wr_state_t          wr_state, wr_next;
    logic [COL_W-1:0]   col, col_n, eff_col;
    logic [2:0]         line, line_n, eff_line;
    logic [BAND_W-1:0]  band, band_n;
    logic               wr_sel, sof_pending, vs_d, hs_d;
    logic               vs_rise, hs_rise, line_err, wr_en, band_done, ovf;
    logic [ADDR_W-1:0]  wr_addr;

    rd_state_t          rd_state, rd_next;
    logic [B_W-1:0]     rd_b, b_n;
    logic [2:0]         rd_r, r_n;
    logic [E_W-1:0]     rd_e, e_n;
    logic               rd_sel, rd_sof, rd_en, rd_last, rd_start;
    logic [ADDR_W-1:0]  rd_addr;
    logic [W-1:0]       rd_data;
    logic               p1_valid, p1_sob, p1_eob, p1_sof;

    assign dbg_wr_state = wr_state;
    assign dbg_rd_state = rd_state;

    // An h_sync edge on a partial line behaves as if the line had wrapped
    assign vs_rise   = hdmi_v_sync & ~vs_d;
    assign hs_rise   = hdmi_h_sync & ~hs_d;
    assign line_err  = (wr_state == WR_ACTIVE) && !vs_rise && hs_rise && (col != '0);
    assign eff_col   = line_err ? '0 : col;
    assign eff_line  = line_err ? line + 3'd1 : line;
    assign wr_en     = (wr_state == WR_ACTIVE) && !vs_rise && hdmi_data_valid;
    assign band_done = wr_en && (eff_line == 3'd7) && (eff_col == COL_LAST);
    assign wr_addr   = ADDR_W'(int'(eff_line) * COLS + int'(eff_col));

    assign rd_en    = (rd_state == RD_BAND);
    assign rd_last  = rd_en && (rd_b == B_LAST) && (rd_r == 3'd7) && (rd_e == E_LAST);
    assign rd_start = band_done && (!rd_en || rd_last);
    assign ovf      = band_done && !rd_start;
    assign rd_addr  = ADDR_W'(int'(rd_r) * COLS + int'(rd_b) * EPB + int'(rd_e));

    always_comb begin
        wr_next = wr_state;
        col_n   = col;
        line_n  = line;
        band_n  = band;
        if (vs_rise) begin
            wr_next = WR_ACTIVE;
            col_n   = '0;
            line_n  = '0;
            band_n  = '0;
        end else if (wr_state == WR_ACTIVE) begin
            col_n  = eff_col;
            line_n = eff_line;
            if (wr_en) begin
                if (eff_col == COL_LAST) begin
                    col_n  = '0;
                    line_n = eff_line + 3'd1;
                end else begin
                    col_n = eff_col + 1'b1;
                end
                if (band_done) begin
                    if (band == BAND_LAST) begin
                        wr_next = WR_DONE;
                        band_n  = '0;
                    end else begin
                        band_n = band + 1'b1;
                    end
                end
            end
        end
    end

    // On overflow the buffer selection is held so the writer never lands in the buffer being read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state    <= WR_WAIT_VS;
            col         <= '0;
            line        <= '0;
            band        <= '0;
            wr_sel      <= 1'b0;
            sof_pending <= 1'b0;
            vs_d        <= 1'b0;
            hs_d        <= 1'b0;
            err_line    <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            wr_state <= wr_next;
            col      <= col_n;
            line     <= line_n;
            band     <= band_n;
            vs_d     <= hdmi_v_sync;
            hs_d     <= hdmi_h_sync;
            err_line <= line_err;
            err_ovf  <= ovf;
            if (rd_start) wr_sel <= ~wr_sel;
            if (vs_rise) sof_pending <= 1'b1;
            else if (rd_start) sof_pending <= 1'b0;
        end
    end

    always_comb begin
        rd_next = rd_state;
        b_n     = rd_b;
        r_n     = rd_r;
        e_n     = rd_e;
        if (rd_start) begin
            rd_next = RD_BAND;
            b_n     = '0;
            r_n     = '0;
            e_n     = '0;
        end else if (rd_en) begin
            if (rd_last) begin
                rd_next = RD_IDLE;
                b_n     = '0;
                r_n     = '0;
                e_n     = '0;
            end else if (rd_e == E_LAST) begin
                e_n = '0;
                if (rd_r == 3'd7) begin
                    r_n = '0;
                    b_n = rd_b + 1'b1;
                end else begin
                    r_n = rd_r + 3'd1;
                end
            end else begin
                e_n = rd_e + 1'b1;
            end
        end
    end

    // Sideband flags travel one stage alongside the RAM read, then share the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state    <= RD_IDLE;
            rd_b        <= '0;
            rd_r        <= '0;
            rd_e        <= '0;
            rd_sel      <= 1'b0;
            rd_sof      <= 1'b0;
            p1_valid    <= 1'b0;
            p1_sob      <= 1'b0;
            p1_eob      <= 1'b0;
            p1_sof      <= 1'b0;
            blk_valid   <= 1'b0;
            blk_sob     <= 1'b0;
            blk_eob     <= 1'b0;
            blk_sof     <= 1'b0;
            blk_data_y  <= '0;
            blk_data_cr <= '0;
            blk_data_cb <= '0;
        end else begin
            rd_state <= rd_next;
            rd_b     <= b_n;
            rd_r     <= r_n;
            rd_e     <= e_n;
            if (rd_start) begin
                rd_sel <= wr_sel;
                rd_sof <= sof_pending;
            end
            p1_valid    <= rd_en;
            p1_sob      <= rd_en && (rd_r == 3'd0) && (rd_e == '0);
            p1_eob      <= rd_en && (rd_r == 3'd7) && (rd_e == E_LAST);
            p1_sof      <= rd_en && rd_sof && (rd_b == '0) && (rd_r == 3'd0) && (rd_e == '0);
            blk_valid   <= p1_valid;
            blk_sob     <= p1_valid & p1_sob;
            blk_eob     <= p1_valid & p1_eob;
            blk_sof     <= p1_valid & p1_sof;
            blk_data_y  <= p1_valid ? rd_data[N*8-1:0]      : '0;
            blk_data_cr <= p1_valid ? rd_data[N*16-1:N*8]   : '0;
            blk_data_cb <= p1_valid ? rd_data[N*24-1:N*16]  : '0;
        end
    end

    band_pingpong_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data ({hdmi_data_cb, hdmi_data_cr, hdmi_data_y}),
        .rd_en   (rd_en),
        .rd_sel  (rd_sel),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_hdmi_to_blocks.sv
// Directed bench for hdmi_to_blocks at N=2, 16x16 raster: pixel = (line*16+x+ofs) mod 128,
// cr = pixel|0x80, cb = pixel^0x40.
module tb_hdmi_to_blocks;
    import hdmi_blk_pkg::*;

    typedef struct {
        logic [50:0] beat;
        int          cyc;
    } obs_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               hdmi_v_sync = 1'b0;
    logic               hdmi_h_sync = 1'b0;
    logic               hdmi_data_valid = 1'b0;
    logic signed [15:0] hdmi_data_y = '0;
    logic signed [15:0] hdmi_data_cr = '0;
    logic signed [15:0] hdmi_data_cb = '0;
    logic               blk_valid, blk_sob, blk_eob, blk_sof, err_ovf, err_line;
    logic signed [15:0] blk_data_y, blk_data_cr, blk_data_cb;
    wr_state_t          dbg_wr_state;
    rd_state_t          dbg_rd_state;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_err_line = 0;
    int          n_err_ovf = 0;
    int          idle_bad = 0;
    int          last_wr_edge = 0;
    int          first_cyc = 0;
    obs_t        obs_q[$];
    logic [50:0] exp_q[$];

    hdmi_to_blocks #(.N(2), .X_RES(16), .Y_RES(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hdmi_v_sync     (hdmi_v_sync),
        .hdmi_h_sync     (hdmi_h_sync),
        .hdmi_data_valid (hdmi_data_valid),
        .hdmi_data_y     (hdmi_data_y),
        .hdmi_data_cr    (hdmi_data_cr),
        .hdmi_data_cb    (hdmi_data_cb),
        .blk_valid       (blk_valid),
        .blk_data_y      (blk_data_y),
        .blk_data_cr     (blk_data_cr),
        .blk_data_cb     (blk_data_cb),
        .blk_sob         (blk_sob),
        .blk_eob         (blk_eob),
        .blk_sof         (blk_sof),
        .err_ovf         (err_ovf),
        .err_line        (err_line),
        .dbg_wr_state    (dbg_wr_state),
        .dbg_rd_state    (dbg_rd_state)
    );

    // Clock and cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: output beats, error pulses, non-zero data while idle
    always @(negedge clk) begin
        if (blk_valid)
            obs_q.push_back('{beat: {blk_sof, blk_sob, blk_eob, blk_data_cb, blk_data_cr, blk_data_y}, cyc: cyc});
        else if (blk_data_y != 0 || blk_data_cr != 0 || blk_data_cb != 0)
            idle_bad++;
        if (err_line) n_err_line++;
        if (err_ovf) n_err_ovf++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int ln, input int x, input int ofs);
        return 8'((ln * 16 + x + ofs) % 128);
    endfunction

    // Beat k of a band: block k/32, row (k%32)/4, element k%4
    function automatic logic [50:0] exp_beat(input int band, input int k, input int ofs,
                                             input bit sof, input int stale_x);
        int b, r, e, ln, x, o;
        logic [7:0] v;
        logic [15:0] y, cr, cb;
        b = k / 32;
        r = (k % 32) / 4;
        e = k % 4;
        ln = band * 8 + r;
        y = '0;
        cr = '0;
        cb = '0;
        for (int l = 0; l < 2; l++) begin
            x = b * 8 + e * 2 + l;
            o = (r == 0 && x >= stale_x) ? 0 : ofs;
            v = pix(ln, x, o);
            y[l*8 +: 8] = v;
            cr[l*8 +: 8] = v | 8'h80;
            cb[l*8 +: 8] = v ^ 8'h40;
        end
        return {(sof && k == 0), (r == 0 && e == 0), (r == 7 && e == 3), cb, cr, y};
    endfunction

    task automatic push_band(input int band, input int ofs, input bit sof, input int stale_x);
        for (int k = 0; k < 64; k++) exp_q.push_back(exp_beat(band, k, ofs, sof, stale_x));
    endtask

    task automatic compare_burst(input string tag, input int first_exp);
        int n, c0, gaps;
        obs_t o;
        logic [50:0] e;
        n = exp_q.size();
        c0 = -1;
        gaps = 0;
        for (int i = 0; i < n; i++) begin
            if (obs_q.size() == 0) break;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (i == 0) c0 = o.cyc;
            else if (o.cyc != c0 + i) gaps++;
            check($sformatf("%s_beat%0d", tag, i), 64'(o.beat), 64'(e));
        end
        check({tag, "_first_cycle"}, 64'(c0), 64'(first_exp));
        check({tag, "_gaps"}, 64'(gaps), 64'd0);
        exp_q.delete();
    endtask

    // Driver tasks
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input int ln, input int x0, input int ofs);
        logic [7:0] v0, v1;
        v0 = pix(ln, x0, ofs);
        v1 = pix(ln, x0 + 1, ofs);
        hdmi_data_valid = 1'b1;
        hdmi_data_y = {v1, v0};
        hdmi_data_cr = {v1 | 8'h80, v0 | 8'h80};
        hdmi_data_cb = {v1 ^ 8'h40, v0 ^ 8'h40};
        last_wr_edge = cyc + 1;
        @(posedge clk);
        #1;
        hdmi_data_valid = 1'b0;
        hdmi_data_y = '0;
        hdmi_data_cr = '0;
        hdmi_data_cb = '0;
    endtask

    task automatic drive_line(input int ln, input int ofs, input int nbeats, input int blank);
        for (int x = 0; x < nbeats; x++) drive_beat(ln, 2 * x, ofs);
        for (int i = 0; i < blank; i++) begin
            hdmi_h_sync = (i == 0);
            @(posedge clk);
            #1;
        end
        hdmi_h_sync = 1'b0;
    endtask

    task automatic drive_band(input int band, input int ofs, input int blank);
        for (int r = 0; r < 8; r++) drive_line(band * 8 + r, ofs, 8, blank);
    endtask

    task automatic vsync_pulse();
        hdmi_v_sync = 1'b1;
        idle(1);
        hdmi_v_sync = 1'b0;
        idle(1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_flags"}, 64'({blk_valid, blk_sob, blk_eob, blk_sof, err_ovf, err_line}), 64'd0);
        check({tag, "_data"}, 64'({blk_data_y, blk_data_cr, blk_data_cb}), 64'd0);
        check({tag, "_wr_state"}, 64'(dbg_wr_state), 64'(WR_WAIT_VS));
        check({tag, "_rd_state"}, 64'(dbg_rd_state), 64'(RD_IDLE));
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Two bands with blanking, then a 17th line that must be ignored
        n_err_line = 0;
        n_err_ovf = 0;
        vsync_pulse();
        drive_band(0, 0, 2);
        first_cyc = last_wr_edge + 2;
        drive_band(1, 0, 2);
        drive_line(16, 0, 8, 2);
        idle(100);
        check("s1_count", 64'(obs_q.size()), 64'd128);
        if (obs_q.size() >= 64) begin
            check("s1_b0_y", 64'(obs_q[0].beat[15:0]), 64'h0100);
            check("s1_b0_sof_sob", 64'(obs_q[0].beat[50:49]), 64'b11);
            check("s1_b4_y", 64'(obs_q[4].beat[15:0]), 64'h1110);
            check("s1_b32_y", 64'(obs_q[32].beat[15:0]), 64'h0908);
            check("s1_b32_sof_sob", 64'(obs_q[32].beat[50:49]), 64'b01);
            check("s1_b31_eob", 64'(obs_q[31].beat[48]), 64'd1);
            check("s1_b63_eob", 64'(obs_q[63].beat[48]), 64'd1);
        end
        push_band(0, 0, 1'b1, 16);
        compare_burst("s1_band0", first_cyc);
        if (obs_q.size() > 0) first_cyc = obs_q[0].cyc;
        push_band(1, 0, 1'b0, 16);
        compare_burst("s1_band1", first_cyc);
        check("s1_err_line", 64'(n_err_line), 64'd0);
        check("s1_err_ovf", 64'(n_err_ovf), 64'd0);
        check("s1_wr_done", 64'(dbg_wr_state), 64'(WR_DONE));

        // Partial line 0 (5 beats) cut short by h_sync
        obs_q.delete();
        n_err_line = 0;
        vsync_pulse();
        drive_line(0, 3, 5, 2);
        for (int r = 1; r < 8; r++) drive_line(r, 3, 8, 2);
        first_cyc = last_wr_edge + 2;
        idle(100);
        check("s2_err_line", 64'(n_err_line), 64'd1);
        check("s2_count", 64'(obs_q.size()), 64'd64);
        push_band(0, 3, 1'b1, 10);
        compare_burst("s2_band0", first_cyc);

        // Back-to-back bands: completion coincides with the last read
        obs_q.delete();
        n_err_ovf = 0;
        vsync_pulse();
        drive_band(0, 5, 0);
        first_cyc = last_wr_edge + 2;
        drive_band(1, 5, 0);
        idle(100);
        check("s3_count", 64'(obs_q.size()), 64'd128);
        check("s3_err_ovf", 64'(n_err_ovf), 64'd0);
        push_band(0, 5, 1'b1, 16);
        push_band(1, 5, 1'b0, 16);
        compare_burst("s3_bands", first_cyc);

        // Second band completes early (short lines) while the first is still being read
        obs_q.delete();
        n_err_ovf = 0;
        n_err_line = 0;
        vsync_pulse();
        drive_band(0, 7, 0);
        first_cyc = last_wr_edge + 2;
        for (int l = 8; l < 15; l++) drive_line(l, 7, 1, 1);
        drive_line(15, 7, 8, 0);
        idle(120);
        check("s4_err_ovf", 64'(n_err_ovf), 64'd1);
        check("s4_err_line", 64'(n_err_line), 64'd7);
        check("s4_count", 64'(obs_q.size()), 64'd64);
        push_band(0, 7, 1'b1, 16);
        compare_burst("s4_band0", first_cyc);

        // Reset during readout beat 20
        obs_q.delete();
        vsync_pulse();
        drive_band(0, 9, 0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (obs_q.size() >= 20) break;
        end
        check("s5_reached_beat20", 64'(obs_q.size()), 64'd20);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_outputs_zero("s5_reset");
        check("s5_no_beat_after_reset", 64'(obs_q.size()), 64'd20);
        obs_q.delete();
        idle(2);
        rst_n = 1'b1;
        drive_band(0, 9, 0);
        idle(100);
        check("s5_no_output_without_vsync", 64'(obs_q.size()), 64'd0);
        vsync_pulse();
        drive_band(0, 11, 0);
        first_cyc = last_wr_edge + 2;
        idle(100);
        check("s5_count", 64'(obs_q.size()), 64'd64);
        push_band(0, 11, 1'b1, 16);
        compare_burst("s5_band0", first_cyc);

        check("idle_data_zero", 64'(idle_bad), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hdmi_to_blocks.md
HDMI_TO_BLOCKS -- requirements
Module: hdmi_to_blocks

Interface
REQ-001 Parameter N, default 2: pixels per beat.
REQ-002 Parameter X_RES, default 2160: active pixels per line; multiple of 8.
REQ-003 Parameter Y_RES, default 1200: active lines per frame; multiple of 8.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 hdmi_v_sync  in  1  frame sync, active high.
REQ-007 hdmi_h_sync  in  1  line sync, active high.
REQ-008 hdmi_data_valid  in  1  active-pixel beat.
REQ-009 hdmi_data_y / hdmi_data_cr / hdmi_data_cb  in  N x 8 signed each  pixel components; lane 0 = leftmost pixel.
REQ-010 blk_valid  out  1  block beat valid.
REQ-011 blk_data_y / blk_data_cr / blk_data_cb  out  N x 8 signed each  block row fragment; lane 0 = leftmost pixel.
REQ-012 blk_sob / blk_eob / blk_sof  out  1 each  start of block, end of block, start of frame; qualified by blk_valid.
REQ-013 err_ovf  out  1  one-cycle pulse: band completed while readout busy.
REQ-014 err_line  out  1  one-cycle pulse: h_sync rising edge with a partial line.

Function
REQ-015 Writer FSM states WR_WAIT_VS, WR_ACTIVE and WR_DONE shall leave reset in WR_WAIT_VS.
REQ-016 A v_sync rising edge in any writer state shall clear col, line and band counters, set sof_pending and enter WR_ACTIVE; a partial band in progress shall be discarded.
REQ-017 In WR_ACTIVE, each hdmi_data_valid beat shall write one 24N-bit word to the write buffer at line*X_RES/N + col, then increment col; col wraps from X_RES/N-1 to 0 and increments line (0..7).
REQ-018 An h_sync rising edge with col != 0 shall pulse err_line, force col to 0 and advance line as a wrap would; with col == 0 it shall have no effect.
REQ-019 Band complete (line 7, col X_RES/N-1 written) shall toggle wr_sel and start readout of the just-filled buffer.
REQ-020 After Y_RES/8 bands the writer shall enter WR_DONE and ignore data beats until the next v_sync rising edge; beats in WR_WAIT_VS shall be ignored.
REQ-021 Reader FSM states RD_IDLE and RD_BAND: RD_BAND shall issue one read per cycle for X_RES*8/N cycles, then return to RD_IDLE.
REQ-022 Read order: block b (0..X_RES/8-1), row r (0..7), element e (0..8/N-1); address = r*X_RES/N + b*8/N + e.
REQ-023 Buffer RAM read latency shall be 1 cycle; outputs shall be registered; first blk_valid shall occur exactly 2 cycles after the band-complete write beat.
REQ-024 blk_valid shall be continuous (no gaps) for the X_RES*8/N beats of a band.
REQ-025 blk_sob shall assert on r=0,e=0; blk_eob on r=7,e=8/N-1; blk_sof together with blk_sob of block 0 of the first band after v_sync, then sof_pending clears.
REQ-026 Band complete while reader is in RD_BAND shall pulse err_ovf; readout continues uninterrupted and the new band is not emitted.
REQ-027 Simultaneous band complete and reader finishing its last read shall start the new readout on the next cycle with no err_ovf.
REQ-028 blk_data_* shall be 0 when blk_valid is 0.

Reset
REQ-029 On rst_n low, all outputs shall be 0, both FSMs idle (WR_WAIT_VS, RD_IDLE), all counters 0, wr_sel 0, sof_pending 0; buffer contents undefined.
REQ-030 Reset asserted mid-band or mid-readout shall abort immediately; no blk_valid until a new v_sync and full band.

Structure
REQ-031 BLOCK_SIZE=8 and the HDMI timing constants shall live in shared package hdmi_blk_pkg, also used by blocks_to_hdmi.
REQ-032 Ping-pong storage shall be one sub-module band_pingpong_ram: two X_RES*8/N x 24N RAMs, one write port, one read port, 1-cycle registered read.

Verification (N=2, X_RES=16, Y_RES=16, pixel value = (line*16+x) mod 128)
REQ-033 v_sync pulse, 8 lines x 8 beats -> 64 continuous blk_valid beats starting 2 cycles after last write; first beat y lanes {0,1}, sob=1, sof=1.
REQ-034 Same stimulus -> beat 4 carries pixels x=0,1 of line 1 (16,17); beat 32 carries x=8,9 of line 0 (8,9) with sob=1, sof=0; beats 31 and 63 have eob=1.
REQ-035 Second band (lines 8..15) -> second 64-beat burst, sof=0 throughout; 17th line beats ignored (no output).
REQ-036 h_sync rising edge after 5 beats of a line -> err_line single pulse; next beat written at col 0 of next line.
REQ-037 Band completes while previous readout active (blanking removed) -> err_ovf one pulse; only first band emitted.
REQ-038 rst_n low during readout beat 20 -> all outputs 0 next cycle; no output until v_sync plus full band.
